// File: rtl/axi_ad7124_emu_pkg.sv
// Shared types and helpers for the AD7124 DOUT/RDY emulator.
package axi_ad7124_emu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    DATA    = 2'd2,
    WAIT_CS = 2'd3
  } state_t;

  localparam int STATUS_WIDTH = 8;

  // Status byte as the AD7124 appends it in DATA_STATUS mode: RDY bit low, channel in the low nibble.
  function automatic logic [STATUS_WIDTH-1:0] status_byte(input logic [3:0] channel);
    return {1'b0, 3'b000, channel};
  endfunction

endpackage

// File: rtl/axi_ad7124_emu_sync.sv
// Two-flop synchroniser for an asynchronous SPI pin, with rise/fall strobes
// derived from the synchronised value versus its one-cycle delay.
module axi_ad7124_emu_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] pipe_q;
  logic [2:0] pipe_d;

  // Shift the raw pin into the synchroniser chain.
  always_comb begin
    pipe_d = {pipe_q[1:0], d_i};
  end

  // Synchroniser and edge-history flops; reset to the pin's idle level so no false edge follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= {3{RESET_VAL}};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign sync_o = pipe_q[1];
  assign rise_o = pipe_q[1] & ~pipe_q[2];
  assign fall_o = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/axi_ad7124_dout_emu.sv
// AD7124 DOUT/RDY emulator: periodic conversion from a stream source, RDY on DOUT, data read on 0x42.
// Define AD7124_EMU_STATUS_EN to append the 8-bit status byte (DATA_STATUS mode) to each read.
module axi_ad7124_dout_emu
  import axi_ad7124_emu_pkg::*;
#(
  parameter int          DATA_WIDTH  = 24,
  parameter int          CONV_CYCLES = 1000,
  parameter logic [7:0]  READ_CMD    = 8'h42
) (
  input  logic                  spi_clk,
  input  logic                  spi_resetn,
  input  logic                  spi_sclk,
  input  logic                  spi_cs,
  input  logic                  spi_sdi,
  output logic                  spi_sdo,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [3:0]            s_tchannel,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic                  overrun
);

`ifdef AD7124_EMU_STATUS_EN
  localparam int XFER_W   = DATA_WIDTH + STATUS_WIDTH;
  localparam int SHADOW_W = DATA_WIDTH + 4;
`else
  localparam int XFER_W   = DATA_WIDTH;
  localparam int SHADOW_W = DATA_WIDTH;
`endif
  localparam int              TW         = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(CONV_CYCLES - 1);
  localparam int              CW         = $clog2(XFER_W + 1);
  localparam logic [CW-1:0]   CMD_LAST   = CW'(7);
  localparam logic [CW-1:0]   XFER_LAST  = CW'(XFER_W - 1);

  logic sclk_s, sclk_rise_s, sclk_fall_s;
  logic cs_s, cs_fall_s, cs_rise_unused_s;
  logic sdi_s, sdi_rise_unused_s, sdi_fall_unused_s;

  axi_ad7124_emu_sync #(.RESET_VAL(1'b1)) u_sync_sclk (
    .clk(spi_clk), .rst_n(spi_resetn), .d_i(spi_sclk),
    .sync_o(sclk_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
  );
  axi_ad7124_emu_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(spi_clk), .rst_n(spi_resetn), .d_i(spi_cs),
    .sync_o(cs_s), .rise_o(cs_rise_unused_s), .fall_o(cs_fall_s)
  );
  axi_ad7124_emu_sync #(.RESET_VAL(1'b1)) u_sync_sdi (
    .clk(spi_clk), .rst_n(spi_resetn), .d_i(spi_sdi),
    .sync_o(sdi_s), .rise_o(sdi_rise_unused_s), .fall_o(sdi_fall_unused_s)
  );

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [XFER_W-1:0]     shift_q, shift_d;
  logic [SHADOW_W-1:0]   shadow_q, shadow_d;
  logic                  rdy_q, rdy_d;
  logic                  sdo_q, sdo_d;

  logic                  tick_s, accept_s, load_s, overrun_s;
  logic [7:0]            cmd_shift_s;
  logic [SHADOW_W-1:0]   sample_s;
  logic [XFER_W-1:0]     load_word_s;

`ifdef AD7124_EMU_STATUS_EN
  assign sample_s    = {s_tdata, s_tchannel};
  assign load_word_s = {shadow_q[SHADOW_W-1:4], status_byte(shadow_q[3:0])};
`else
  logic [3:0] chan_unused_s;
  assign chan_unused_s = s_tchannel;
  assign sample_s      = s_tdata;
  assign load_word_s   = shadow_q;
`endif

  assign tick_s      = (timer_q == TIMER_LAST);
  assign accept_s    = tick_s & s_tvalid;
  assign cmd_shift_s = {cmd_q[6:0], sdi_s};

  // Transfer FSM; a high CS overrides everything and returns to IDLE.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    shift_d   = shift_q;
    load_s    = 1'b0;
    if (cs_s) begin
      state_d   = IDLE;
      bit_cnt_d = {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall_s) begin
            state_d   = CMD;
            bit_cnt_d = {CW{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        CMD: begin
          if (sclk_rise_s) begin
            cmd_d     = cmd_shift_s;
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CMD_LAST) begin
              bit_cnt_d = {CW{1'b0}};
              if ((cmd_shift_s == READ_CMD) && rdy_q) begin
                state_d = DATA;
                shift_d = load_word_s;
                load_s  = 1'b1;
              end else begin
                state_d = WAIT_CS;
              end
            end else begin
              state_d = CMD;
            end
          end else begin
            state_d = CMD;
          end
        end
        DATA: begin
          // The MSB is already on DOUT after the load, so the first fall holds it.
          if (sclk_fall_s) begin
            if (bit_cnt_q != {CW{1'b0}}) begin
              shift_d = {shift_q[XFER_W-2:0], 1'b0};
            end else begin
              shift_d = shift_q;
            end
          end else if (sclk_rise_s) begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == XFER_LAST) begin
              state_d = WAIT_CS;
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = DATA;
          end
        end
        WAIT_CS: state_d = WAIT_CS;
        default: state_d = IDLE;
      endcase
    end
  end

  // Conversion tick, sample capture and RDY bookkeeping; a read loading at the tick takes the old shadow.
  always_comb begin
    timer_d   = tick_s ? {TW{1'b0}} : timer_q + TW'(1);
    rdy_d     = rdy_q;
    shadow_d  = shadow_q;
    overrun_s = 1'b0;
    if (accept_s) begin
      rdy_d     = 1'b1;
      shadow_d  = sample_s;
      overrun_s = rdy_q & ~load_s;
    end else if (load_s) begin
      rdy_d = 1'b0;
    end else begin
      rdy_d = rdy_q;
    end
    if (cs_s) begin
      sdo_d = 1'b1;
    end else if (state_d == DATA) begin
      sdo_d = shift_d[XFER_W-1];
    end else begin
      sdo_d = ~rdy_d;
    end
  end

  // State registers.
  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      state_q   <= IDLE;
      timer_q   <= {TW{1'b0}};
      bit_cnt_q <= {CW{1'b0}};
      cmd_q     <= 8'h00;
      shift_q   <= {XFER_W{1'b0}};
      shadow_q  <= {SHADOW_W{1'b0}};
      rdy_q     <= 1'b0;
      sdo_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      rdy_q     <= rdy_d;
      sdo_q     <= sdo_d;
    end
  end

  assign spi_sdo  = sdo_q;
  assign s_tready = accept_s;
  assign overrun  = overrun_s;

endmodule

// File: tb/tb_axi_ad7124_dout_emu.sv
// Scoreboarded bench for axi_ad7124_dout_emu: directed conversions, reads, rejects, overrun and abort.
module tb_axi_ad7124_dout_emu;

  localparam int DW   = 24;
  localparam int CC   = 100;
  localparam int HALF = 6;
`ifdef AD7124_EMU_STATUS_EN
  localparam int XW = DW + 8;
`else
  localparam int XW = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b1;
  logic          cs = 1'b1;
  logic          sdi = 1'b1;
  logic          sdo;
  logic [DW-1:0] tdata = '0;
  logic [3:0]    tchan = 4'h5;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          ovr;

  axi_ad7124_dout_emu #(.DATA_WIDTH(DW), .CONV_CYCLES(CC), .READ_CMD(8'h42)) dut (
    .spi_clk(clk), .spi_resetn(rst_n), .spi_sclk(sclk), .spi_cs(cs), .spi_sdi(sdi),
    .spi_sdo(sdo), .s_tdata(tdata), .s_tchannel(tchan), .s_tvalid(tvalid),
    .s_tready(tready), .overrun(ovr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ov_cnt   = 0;
  int last_tick_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ovr) ov_cnt <= ov_cnt + 1;

  typedef struct {
    int          id;
    logic [39:0] val;
  } exp_t;
  exp_t        exp_q[$];
  logic [39:0] rx_word;
  event        rx_done;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: each completed master read is compared with the oldest queued expectation.
  always @(rx_done) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL read_unexpected: got %0h, expected no read", rx_word);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("read%0d", e.id), rx_word, e.val);
    end
  end

  function automatic logic [39:0] exp_word(input logic [DW-1:0] d);
`ifdef AD7124_EMU_STATUS_EN
    return 40'({d, 8'h05});
`else
    return 40'(d);
`endif
  endfunction

  task automatic expect_read(input int id, input logic [39:0] v);
    exp_t e;
    e.id  = id;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic sclk_bit(input logic din, output logic dout);
    sclk = 1'b0;
    sdi  = din;
    repeat (HALF) @(posedge clk);
    #1;
    dout = sdo;
    sclk = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic master_xfer(input logic [7:0] cmd, input int nbits);
    logic        b;
    logic [39:0] w;
    for (int i = 7; i >= 0; i--) sclk_bit(cmd[i], b);
    w = '0;
    for (int i = 0; i < nbits; i++) begin
      sclk_bit(1'b1, b);
      w = {w[38:0], b};
    end
    rx_word = w;
    ->rx_done;
    #1;
  endtask

  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * CC; i++) begin
      @(negedge clk);
      if (tready) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: got no s_tready within %0d cycles, expected a tick", name, 3 * CC);
    end
    last_tick_cyc = cyc;
  endtask

  task automatic load_sample(input string name, input logic [DW-1:0] d);
    tdata  = d;
    tvalid = 1'b1;
    wait_tick(name);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
  endtask

  initial begin
    int r0, t1, ov0;
    logic [39:0] all_ones;
    all_ones = (40'd1 << XW) - 40'd1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sdo", 40'(sdo), 40'd1);
    check("rst_tready", 40'(tready), 40'd0);
    check("rst_overrun", 40'(ovr), 40'd0);

    // Conversion with CS held low: RDY on DOUT one cycle after the tick.
    @(posedge clk);
    #1;
    r0     = cyc;
    rst_n  = 1'b1;
    cs     = 1'b0;
    tdata  = 24'hA5C3F0;
    tvalid = 1'b1;
    wait_tick("tick1");
    check("first_tick_cycle", 40'(last_tick_cyc - r0), 40'd99);
    check("sdo_at_tick", 40'(sdo), 40'd1);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    @(negedge clk);
    check("sdo_rdy_fall", 40'(sdo), 40'd0);
    check("tready_one_cycle", 40'(tready), 40'd0);

    expect_read(1, exp_word(24'hA5C3F0));
    master_xfer(8'h42, XW);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sdo_after_read", 40'(sdo), 40'd1);
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("sdo_idle_high", 40'(sdo), 40'd1);
    cs = 1'b1;
    repeat (HALF) @(posedge clk);

    // Non-read command is rejected; RDY stays asserted until CS rises.
    cs = 1'b0;
    repeat (HALF) @(posedge clk);
    load_sample("tick_reject", 24'h123456);
    @(negedge clk);
    check("rdy_low_before_cmd", 40'(sdo), 40'd0);
    expect_read(2, 40'h0);
    master_xfer(8'h40, 8);
    @(negedge clk);
    check("sdo_held_wait_cs", 40'(sdo), 40'd0);
    @(posedge clk);
    #1;
    cs = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sdo_cs_high", 40'(sdo), 40'd1);
    cs = 1'b0;
    repeat (HALF) @(posedge clk);
    expect_read(3, exp_word(24'h123456));
    master_xfer(8'h42, XW);
    cs = 1'b1;
    repeat (HALF) @(posedge clk);

    // Two conversions without a read: one overrun pulse, newest sample wins.
    ov0    = ov_cnt;
    tdata  = 24'h000001;
    tvalid = 1'b1;
    wait_tick("tick_ov1");
    check("no_overrun_first", 40'(ovr), 40'd0);
    t1 = last_tick_cyc;
    @(posedge clk);
    #1;
    tdata = 24'h000002;
    wait_tick("tick_ov2");
    check("overrun_second", 40'(ovr), 40'd1);
    check("tick_period", 40'(last_tick_cyc - t1), 40'(CC));
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    repeat (3) @(posedge clk);
    check("overrun_count", 40'(ov_cnt - ov0), 40'd1);
    cs = 1'b0;
    repeat (HALF) @(posedge clk);
    expect_read(4, exp_word(24'h000002));
    master_xfer(8'h42, XW);
    cs = 1'b1;
    repeat (HALF) @(posedge clk);

    // Abort after 10 data bits: sample is lost and the next read is refused.
    ov0 = ov_cnt;
    cs  = 1'b0;
    repeat (HALF) @(posedge clk);
    load_sample("tick_abort", 24'hABCDEF);
    expect_read(5, 40'h2AF);
    master_xfer(8'h42, 10);
    cs = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sdo_after_abort", 40'(sdo), 40'd1);
    @(posedge clk);
    #1;
    cs = 1'b0;
    repeat (HALF) @(posedge clk);
    expect_read(6, all_ones);
    master_xfer(8'h42, XW);
    check("no_overrun_on_abort", 40'(ov_cnt - ov0), 40'd0);
    cs = 1'b1;

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 40'(exp_q.size()), 40'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
